// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to imem,
// buffers returned words and presents the head instruction to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        incr_pc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] d_inst_o,
    output logic        d_inst_valid_o,
    output logic [31:0] d_pc_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    logic [31:0]   pc_q;
    logic [31:0]   head_pc_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] os_q;
    logic [CW-1:0] discard_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [31:0]   buf_q [FIFO_DEPTH];

    logic [CW:0]   credit_sum;
    logic          fire;
    logic          rv_eff;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW-1:0] os_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   redirect_target;
    logic          unused_rpc_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc_i[1:0];

    // Every outstanding request owns a FIFO slot, so a response can always be pushed.
    assign credit_sum = {1'b0, os_q} + {1'b0, cnt_q};
    assign imem_req_o = !rst_i && !redirect_i && (credit_sum < {1'b0, DEPTH_C});
    assign imem_addr_o = pc_q;

    assign fire   = imem_req_o && imem_gnt_i;
    assign rv_eff = imem_rvalid_i && (os_q != '0);
    assign drop   = rv_eff && (discard_q != '0);
    assign push   = rv_eff && !drop;
    assign pop    = incr_pc_i && (cnt_q != '0);

    always_comb begin
        os_nxt = os_q;
        if (fire) begin
            os_nxt = os_nxt + CW'(1);
        end
        if (rv_eff) begin
            os_nxt = os_nxt - CW'(1);
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (push && !pop) begin
            cnt_nxt = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            head_pc_q <= RESET_PC;
            cnt_q     <= '0;
            os_q      <= '0;
            discard_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            os_q <= os_nxt;
            if (redirect_i) begin
                pc_q      <= redirect_target;
                head_pc_q <= redirect_target;
                cnt_q     <= '0;
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                // No grant during a redirect, so everything still in flight is stale.
                discard_q <= os_nxt;
            end else begin
                if (fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (drop) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q  <= ptr_inc(rd_ptr_q);
                    head_pc_q <= head_pc_q + 32'd4;
                end
                cnt_q <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !redirect_i && push) begin
            buf_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    assign d_inst_valid_o = (cnt_q != '0);
    assign d_inst_o       = d_inst_valid_o ? buf_q[rd_ptr_q] : NOP;
    assign d_pc_o         = head_pc_q;

endmodule
